// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared constants and types for the FIFO write-arbiter controller
package fifo_ctrl_pkg;
    localparam int FIFO_DATA_W  = 4;
    localparam int FIFO_DEPTH   = 4;
    localparam int FIFO_LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    typedef logic [FIFO_LEVEL_W-1:0] level_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, priority starts one past the last winner
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] gnt
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] last_gnt;
    logic [IW-1:0] idx;
    logic [IW-1:0] sel;
    logic          hit;
    always_comb begin
        gnt = '0;
        sel = last_gnt;
        idx = last_gnt;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
            if (rstN && enable && req[idx] && !hit) begin
                gnt[idx] = 1'b1;
                sel      = idx;
                hit      = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rstN)
        if (!rstN)
            last_gnt <= IW'(N - 1);
        else if (hit)
            last_gnt <= sel;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbitration, read prefetch and level shadow
// for a shared FIFO; the only agent driving the FIFO's write and read strobes.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int DEPTH   = FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        pop_valid,
    input  logic                        pop_ready,
    output logic [DATA_W-1:0]           pop_data,
    output logic                        fifo_write_en,
    output logic [DATA_W-1:0]           fifo_write_data,
    output logic                        fifo_read_en,
    input  logic [DATA_W-1:0]           fifo_read_data,
    input  logic                        fifo_full,
    input  logic                        fifo_empty,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        err
);
    localparam int LW = $clog2(DEPTH) + 1;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk    (clk),
        .rstN   (rstN),
        .req    (req),
        .enable (!fifo_full),
        .gnt    (gnt)
    );
    always_comb begin
        fifo_write_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            fifo_write_data = fifo_write_data | (gnt[i] ? req_data[i*DATA_W +: DATA_W] : '0);
    end
    assign fifo_write_en = |gnt;
    // Refill only when the output register is empty or being drained this cycle.
    assign fifo_read_en = rstN && (!pop_valid || pop_ready) && !fifo_empty;
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) begin
            pop_valid <= 1'b0;
            pop_data  <= '0;
            level     <= '0;
            err       <= 1'b0;
        end else begin
            if (fifo_read_en) begin
                pop_valid <= 1'b1;
                pop_data  <= fifo_read_data;
            end else if (pop_ready)
                pop_valid <= 1'b0;
            if (fifo_write_en != fifo_read_en)
                level <= fifo_write_en ? level + LW'(1) : level - LW'(1);
            if ((fifo_empty != (level == '0)) || (fifo_full != (level == LW'(DEPTH))))
                err <= 1'b1;
        end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed table, corner sequences and random traffic against
// a queue-based reference model; includes a behavioural 4-deep FIFO.
module tb_fifo_wr_arbiter;
    import fifo_ctrl_pkg::*;
    localparam int N = 4;
    localparam int W = FIFO_DATA_W;
    localparam int D = FIFO_DEPTH;

    logic           clk = 1'b0;
    logic           rstN = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic           pop_ready = 1'b0;
    logic [N-1:0]   gnt;
    logic           pop_valid;
    logic [W-1:0]   pop_data;
    logic           fifo_write_en;
    logic [W-1:0]   fifo_write_data;
    logic           fifo_read_en;
    logic [W-1:0]   fifo_read_data;
    logic           fifo_full;
    logic           fifo_empty;
    level_t         level;
    logic           err;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .DEPTH(D)) dut (
        .clk(clk), .rstN(rstN), .req(req), .req_data(req_data), .gnt(gnt),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
        .fifo_read_en(fifo_read_en), .fifo_read_data(fifo_read_data),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .level(level), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO sitting behind the controller.
    logic [W-1:0] mem [D];
    logic [1:0]   wp = '0;
    logic [1:0]   rp = '0;
    int           cnt = 0;
    assign fifo_read_data = mem[rp];
    assign fifo_full  = (cnt == D);
    assign fifo_empty = (cnt == 0);
    always @(posedge clk or negedge rstN)
        if (!rstN) begin
            wp <= '0; rp <= '0; cnt <= 0;
        end else begin
            if (fifo_write_en && cnt < D) begin
                mem[wp] <= fifo_write_data;
                wp <= wp + 2'd1;
            end
            if (fifo_read_en && cnt > 0) rp <= rp + 2'd1;
            cnt <= cnt + ((fifo_write_en && cnt < D) ? 1 : 0) - ((fifo_read_en && cnt > 0) ? 1 : 0);
        end

    int tests = 0;
    int fails = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, output register, round-robin pointer.
    logic [W-1:0] mq [$];
    logic [W-1:0] popped [$];
    int           m_last;
    logic         m_pv;
    logic [W-1:0] m_pd;
    int           m_g;
    bit           auto_drop;
    logic [N-1:0] o_gnt;
    logic         o_re;
    logic         o_pv;
    logic [W-1:0] o_pd;
    int           o_lvl;
    int           dcnt = 0;

    task automatic model_reset();
        mq.delete();
        m_last = N - 1;
        m_pv = 1'b0;
        m_pd = '0;
        m_g = -1;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic step();
        int g;
        logic [W-1:0] ed;
        logic er;
        @(negedge clk);
        g = -1;
        ed = '0;
        if (mq.size() < D)
            for (int k = 1; k <= N; k++)
                if (g < 0 && req[(m_last + k) % N]) g = (m_last + k) % N;
        if (g >= 0) ed = req_data[g*W +: W];
        er = (!m_pv || pop_ready) && mq.size() > 0;
        o_gnt = gnt; o_re = fifo_read_en; o_pv = pop_valid; o_pd = pop_data; o_lvl = int'(level);
        if (pop_valid && pop_ready) popped.push_back(pop_data);
        chk("gnt", 32'(gnt), g >= 0 ? 32'(1) << g : 32'(0));
        chk("wr_en", 32'(fifo_write_en), 32'(g >= 0));
        chk("wr_data", 32'(fifo_write_data), 32'(ed));
        chk("rd_en", 32'(fifo_read_en), 32'(er));
        chk("pop_valid", 32'(pop_valid), 32'(m_pv));
        chk("pop_data", 32'(pop_data), 32'(m_pd));
        chk("level", 32'(level), 32'(mq.size()));
        chk("err", 32'(err), 32'(0));
        @(posedge clk);
        if (er) begin
            m_pd = mq.pop_front();
            m_pv = 1'b1;
        end else if (pop_ready)
            m_pv = 1'b0;
        if (g >= 0) begin
            mq.push_back(ed);
            m_last = g;
        end
        m_g = g;
        #1;
        if (auto_drop && g >= 0) req[g] = 1'b0;
    endtask

    task automatic drain();
        req = '0;
        pop_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic [N-1:0] gnt;
        logic         rd;
        int           lvl;
        logic         pv;
    } vec_t;
    vec_t tbl [7];

    initial begin
        tbl[0] = '{4'b0101, 1'b0, 4'b0001, 1'b0, 0, 1'b0};
        tbl[1] = '{4'b0101, 1'b0, 4'b0100, 1'b1, 1, 1'b0};
        tbl[2] = '{4'b0101, 1'b0, 4'b0001, 1'b0, 1, 1'b1};
        tbl[3] = '{4'b0101, 1'b0, 4'b0100, 1'b0, 2, 1'b1};
        tbl[4] = '{4'b0101, 1'b0, 4'b0001, 1'b0, 3, 1'b1};
        tbl[5] = '{4'b0101, 1'b0, 4'b0000, 1'b0, 4, 1'b1};
        tbl[6] = '{4'b0101, 1'b0, 4'b0000, 1'b0, 4, 1'b1};
        model_reset();

        // Reset with requests pending: strobes forced low, state cleared.
        req = 4'b1111;
        #2 rstN = 1'b0;
        #2;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_wr_en", 32'(fifo_write_en), 32'(0));
        chk("rst_rd_en", 32'(fifo_read_en), 32'(0));
        chk("rst_pop_valid", 32'(pop_valid), 32'(0));
        chk("rst_pop_data", 32'(pop_data), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        req = '0;
        @(posedge clk);
        #1 rstN = 1'b1;

        // Alternating grants 0,2 until the FIFO fills with no consumer.
        req_data = {4'h4, 4'h3, 4'h2, 4'h1};
        auto_drop = 1'b0;
        for (int i = 0; i < 7; i++) begin
            req = tbl[i].req;
            pop_ready = tbl[i].rdy;
            step();
            chk("tbl_gnt", 32'(o_gnt), 32'(tbl[i].gnt));
            chk("tbl_rd_en", 32'(o_re), 32'(tbl[i].rd));
            chk("tbl_level", 32'(o_lvl), 32'(tbl[i].lvl));
            chk("tbl_pop_valid", 32'(o_pv), 32'(tbl[i].pv));
        end
        drain();

        // Push-to-pop latency of an isolated write.
        auto_drop = 1'b1;
        set_data(1, 4'hA);
        req = 4'b0010;
        step();
        chk("lat_gnt", 32'(o_gnt), 32'(4'b0010));
        step();
        chk("lat_rd_en", 32'(o_re), 32'(1));
        chk("lat_pv_early", 32'(o_pv), 32'(0));
        step();
        chk("lat_pv", 32'(o_pv), 32'(1));
        chk("lat_pd", 32'(o_pd), 32'(4'hA));
        step();
        chk("lat_pv_clear", 32'(o_pv), 32'(0));

        // Backpressure: held output register blocks refills.
        pop_ready = 1'b0;
        set_data(0, 4'h5);
        req = 4'b0001;
        step();
        step();
        req_data = {4'h8, 4'h7, 4'h6, 4'h5};
        req = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_pd", 32'(o_pd), 32'(4'h5));
            chk("bp_rd_en", 32'(o_re), 32'(0));
        end

        // Full FIFO with requesters always re-queueing, consumer toggling.
        auto_drop = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 30; i++) begin
            pop_ready = (i >= 6) && (i % 2 == 0);
            step();
            if (o_lvl == D) chk("full_no_gnt", 32'(o_gnt), 32'(0));
            if (m_g >= 0) begin
                set_data(m_g, 4'(dcnt));
                dcnt++;
            end
        end
        drain();

        // Async reset mid-burst at level 3, then requester 0 wins first.
        auto_drop = 1'b1;
        pop_ready = 1'b0;
        req_data = {4'h4, 4'h3, 4'h2, 4'h1};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_level", 32'(o_lvl), 32'(3));
        req = 4'b1111;
        #2 rstN = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'(0));
        chk("arst_wr_en", 32'(fifo_write_en), 32'(0));
        chk("arst_rd_en", 32'(fifo_read_en), 32'(0));
        chk("arst_pop_valid", 32'(pop_valid), 32'(0));
        chk("arst_pop_data", 32'(pop_data), 32'(0));
        chk("arst_level", 32'(level), 32'(0));
        model_reset();
        @(posedge clk);
        #1 rstN = 1'b1;
        pop_ready = 1'b1;
        popped.delete();
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 4) chk("rr_order", 32'(o_gnt), 32'(1) << i);
        end
        chk("pop_count", 32'(popped.size()), 32'(4));
        for (int i = 0; i < popped.size() && i < 4; i++)
            chk("pop_order", 32'(popped[i]), 32'(i + 1));

        // Random traffic: requests arrive, occasionally withdraw, consumer stalls.
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < N; r++) begin
                if (!req[r] && $urandom_range(2) == 0) begin
                    req[r] = 1'b1;
                    set_data(r, 4'($urandom));
                end else if (req[r] && $urandom_range(15) == 0)
                    req[r] = 1'b0;
            end
            pop_ready = ($urandom_range(2) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
